// File: rtl/kernel_pkg.sv
// Shared constants and FSM encoding for the kernel register-file loader.
// Optional feature macro used by the loader: KERNEL_LOAD_CHECKSUM_EN.
package kernel_pkg;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 9;
    localparam int RF_DEPTH   = 512;
    localparam int NUM_KERNEL = 4;
    localparam int LANE_W     = $clog2(NUM_KERNEL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;
endpackage

// File: rtl/kernel_rf_loader.sv
// Gathers four streamed weights per address and writes them to four kernel banks in one cycle.
// Define KERNEL_LOAD_CHECKSUM_EN to add a running signed checksum output of accepted weights.
module kernel_rf_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          num_addr,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     kernel_rf_en,
    output logic                     kernel_rf_wr_en,
    output logic [ADDR_W-1:0]        kernel_rf_wr_addr,
    output logic signed [DATA_W-1:0] kernel1_rf_wr_data,
    output logic signed [DATA_W-1:0] kernel2_rf_wr_data,
    output logic signed [DATA_W-1:0] kernel3_rf_wr_data,
    output logic signed [DATA_W-1:0] kernel4_rf_wr_data,
`ifdef KERNEL_LOAD_CHECKSUM_EN
    output logic signed [DATA_W+ADDR_W+1:0] checksum,
`endif
    output logic                     busy,
    output logic                     done
);
    import kernel_pkg::*;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_KERNEL - 1);

    state_e                    state_q, state_d;
    logic [LANE_W-1:0]         lane_cnt_q, lane_cnt_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [ADDR_W:0]           rem_q, rem_d;
    logic signed [DATA_W-1:0]  lane_q [NUM_KERNEL];
    logic signed [DATA_W-1:0]  lane_d [NUM_KERNEL];
    logic                      in_ready_q, in_ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      bank_en_n_q, bank_en_n_d;
    logic                      hs;

`ifdef KERNEL_LOAD_CHECKSUM_EN
    localparam int CSUM_W = DATA_W + ADDR_W + 2;
    logic signed [CSUM_W-1:0]  csum_q, csum_d;
`endif

    // in_ready is a registered copy of (state == GATHER), so it doubles as the accept qualifier
    assign hs = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        lane_d     = lane_q;
`ifdef KERNEL_LOAD_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = base_addr;
                    rem_d      = num_addr;
                    lane_cnt_d = '0;
`ifdef KERNEL_LOAD_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = (num_addr == '0) ? ST_DONE : ST_GATHER;
                end
            end
            ST_GATHER: begin
                if (hs) begin
                    lane_d[lane_cnt_q] = in_data;
                    lane_cnt_d         = lane_cnt_q + LANE_W'(1);
`ifdef KERNEL_LOAD_CHECKSUM_EN
                    csum_d             = csum_q + CSUM_W'(in_data);
`endif
                    if (lane_cnt_q == LANE_LAST) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                addr_d     = addr_q + ADDR_W'(1);
                rem_d      = rem_q - (ADDR_W+1)'(1);
                lane_cnt_d = '0;
                state_d    = (rem_q == (ADDR_W+1)'(1)) ? ST_DONE : ST_GATHER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it once registered
        in_ready_d  = (state_d == ST_GATHER);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        bank_en_n_d = (state_d != ST_WRITE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lane_cnt_q  <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bank_en_n_q <= 1'b1;
            for (int i = 0; i < NUM_KERNEL; i++) begin
                lane_q[i] <= '0;
            end
`ifdef KERNEL_LOAD_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bank_en_n_q <= bank_en_n_d;
            lane_q      <= lane_d;
`ifdef KERNEL_LOAD_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign in_ready           = in_ready_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign kernel_rf_en       = bank_en_n_q;
    assign kernel_rf_wr_en    = bank_en_n_q;
    assign kernel_rf_wr_addr  = addr_q;
    assign kernel1_rf_wr_data = lane_q[0];
    assign kernel2_rf_wr_data = lane_q[1];
    assign kernel3_rf_wr_data = lane_q[2];
    assign kernel4_rf_wr_data = lane_q[3];
`ifdef KERNEL_LOAD_CHECKSUM_EN
    assign checksum           = csum_q;
`endif

endmodule

// File: tb/tb_kernel_rf_loader.sv
// Scoreboard bench for kernel_rf_loader: stimulus queues expected bank writes and done events,
// a negedge monitor pops and compares them. Honours KERNEL_LOAD_CHECKSUM_EN when defined.
module tb_kernel_rf_loader;
    localparam int DW = 16;
    localparam int AW = 9;
    localparam int CW = DW + AW + 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [AW:0]          num_addr;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;
    logic                 kernel_rf_en;
    logic                 kernel_rf_wr_en;
    logic [AW-1:0]        kernel_rf_wr_addr;
    logic signed [DW-1:0] kernel1_rf_wr_data;
    logic signed [DW-1:0] kernel2_rf_wr_data;
    logic signed [DW-1:0] kernel3_rf_wr_data;
    logic signed [DW-1:0] kernel4_rf_wr_data;
`ifdef KERNEL_LOAD_CHECKSUM_EN
    logic signed [CW-1:0] checksum;
`endif
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    kernel_rf_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .base_addr          (base_addr),
        .num_addr           (num_addr),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .kernel_rf_en       (kernel_rf_en),
        .kernel_rf_wr_en    (kernel_rf_wr_en),
        .kernel_rf_wr_addr  (kernel_rf_wr_addr),
        .kernel1_rf_wr_data (kernel1_rf_wr_data),
        .kernel2_rf_wr_data (kernel2_rf_wr_data),
        .kernel3_rf_wr_data (kernel3_rf_wr_data),
        .kernel4_rf_wr_data (kernel4_rf_wr_data),
`ifdef KERNEL_LOAD_CHECKSUM_EN
        .checksum           (checksum),
`endif
        .busy               (busy),
        .done               (done)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] d3;
    } exp_wr_t;

    exp_wr_t       exp_wr[$];
    logic [CW-1:0] exp_done[$];
    int            w_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic          prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_random(input int n);
        logic [DW-1:0] t;
        for (int i = 0; i < n; i++) begin
            t = DW'($urandom);
            w_q.push_back(int'($signed(t)));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_rf_en"}, 64'(kernel_rf_en), 64'(1));
        check({tag, "_rf_wr_en"}, 64'(kernel_rf_wr_en), 64'(1));
        check({tag, "_wr_addr"}, 64'(kernel_rf_wr_addr), 64'(0));
        check({tag, "_lanes"}, 64'({kernel1_rf_wr_data, kernel2_rf_wr_data,
                                    kernel3_rf_wr_data, kernel4_rf_wr_data}), 64'(0));
    endtask

    // mode 0: continuous in_valid, 1: alternating in_valid with stray start pulses, 2: random stalls
    task automatic run_load(input int base, input int num, input int mode, input int abort_n);
        int      w[$];
        int      idx = 0;
        int      cyc = 0;
        int      limit;
        longint  sum = 0;
        logic    hs;
        exp_wr_t e;
        w   = w_q;
        w_q = {};
        if (abort_n == 0) begin
            for (int i = 0; i < num; i++) begin
                e.addr = AW'((base + i) % 512);
                e.d0   = DW'(w[4*i]);
                e.d1   = DW'(w[4*i+1]);
                e.d2   = DW'(w[4*i+2]);
                e.d3   = DW'(w[4*i+3]);
                exp_wr.push_back(e);
            end
            for (int i = 0; i < num * 4; i++) sum += longint'(w[i]);
            exp_done.push_back(CW'(sum));
        end
        start     = 1'b1;
        base_addr = AW'(base);
        num_addr  = (AW+1)'(num);
        @(posedge clk); #1;
        start = 1'b0;
        if (num == 0) begin
            check("zero_done_next_cycle", 64'(done), 64'(1));
            check("zero_busy_one_cycle", 64'(busy), 64'(1));
            @(posedge clk); #1;
            check("zero_done_cleared", 64'(done), 64'(0));
            check("zero_busy_cleared", 64'(busy), 64'(0));
        end else begin
            limit = (abort_n != 0) ? abort_n : num * 4;
            while (idx < limit && cyc < 20000) begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (cyc[0] == 1'b0);
                    default: in_valid = ($urandom_range(99) >= 40);
                endcase
                if (mode == 1) begin
                    start     = !in_valid;
                    base_addr = AW'($urandom);
                end
                in_data = DW'(w[idx]);
                hs      = in_valid && in_ready;
                @(posedge clk); #1;
                cyc++;
                if (hs) begin
                    idx++;
                    if (idx % 4 == 0) check("write_latency", 64'(kernel_rf_en), 64'(0));
                end
            end
            in_valid = 1'b0;
            start    = 1'b0;
            if (idx < limit) begin
                n_vec++;
                n_err++;
                $display("FAIL feed_timeout: accepted %0d of %0d words", idx, limit);
            end
            if (abort_n != 0) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check_idle("after_abort");
            end else begin
                for (int k = 0; k < 10 && busy; k++) begin
                    @(posedge clk); #1;
                end
                check("load_finished", 64'(busy), 64'(0));
            end
        end
        $display("load base=%0d num=%0d mode=%0d abort_after=%0d complete", base, num, mode, abort_n);
    endtask

    // Monitor: compares every bank write and done pulse against the scoreboard
    initial begin
        exp_wr_t       e;
        logic [CW-1:0] cs;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!kernel_rf_en || !kernel_rf_wr_en) begin
                    if (exp_wr.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_write: addr %0d, none expected", kernel_rf_wr_addr);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_enables", 64'({kernel_rf_en, kernel_rf_wr_en}), 64'(0));
                        check("wr_addr", 64'(kernel_rf_wr_addr), 64'(e.addr));
                        check("wr_data", 64'({kernel1_rf_wr_data, kernel2_rf_wr_data,
                                              kernel3_rf_wr_data, kernel4_rf_wr_data}),
                              64'({e.d0, e.d1, e.d2, e.d3}));
                        check("in_ready_in_write", 64'(in_ready), 64'(0));
                        $display("write addr=%0d data=%0d %0d %0d %0d", kernel_rf_wr_addr,
                                 kernel1_rf_wr_data, kernel2_rf_wr_data,
                                 kernel3_rf_wr_data, kernel4_rf_wr_data);
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done: done pulse with no load pending");
                    end else begin
                        cs = exp_done.pop_front();
                        check("writes_before_done", 64'(exp_wr.size()), 64'(0));
                        check("busy_at_done", 64'(busy), 64'(1));
`ifdef KERNEL_LOAD_CHECKSUM_EN
                        check("checksum", 64'($unsigned(checksum)), 64'(cs));
`endif
                        $display("done pulse, expected sum=%0d", $signed(cs));
                    end
                end
                if (prev_done && done) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL done_width: done high for two cycles");
                end
                check("in_ready_implies_busy", 64'(in_ready && !busy), 64'(0));
                prev_done = done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_addr  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        w_q = '{1, 2, 3, 4};
        run_load(0, 1, 0, 0);
        fill_random(12);
        run_load(510, 3, 2, 0);
        run_load(5, 0, 0, 0);
        fill_random(8);
        run_load(100, 2, 1, 0);
        fill_random(4);
        run_load(7, 1, 0, 2);
        fill_random(4);
        run_load(8, 1, 0, 0);
`ifdef KERNEL_LOAD_CHECKSUM_EN
        w_q = '{-5, 7, 100, -2};
        run_load(20, 1, 0, 0);
        run_load(21, 0, 0, 0);
`endif
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(6, 1);
            fill_random(n * 4);
            run_load(int'($urandom_range(511)), n, int'($urandom_range(2)), 0);
        end
        fill_random(2048);
        run_load(300, 512, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("pending_writes", 64'(exp_wr.size()), 64'(0));
        check("pending_done", 64'(exp_done.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kernel_rf_loader.md
KERNEL_RF_LOADER -- requirements
Module: kernel_rf_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of one signed kernel weight.
REQ-002 SHALL have parameter ADDR_W, default 9, kernel register-file address width (512 entries per bank).
REQ-003 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a load.
REQ-006 SHALL have port base_addr, input, ADDR_W, first register-file address written, sampled on an accepted start.
REQ-007 SHALL have port num_addr, input, ADDR_W+1, number of addresses to fill (0..512), sampled on an accepted start.
REQ-008 SHALL have port in_valid, input, 1, a weight is present on in_data.
REQ-009 SHALL have port in_data, input signed, DATA_W, the weight stream.
REQ-010 SHALL have port in_ready, output, 1, the loader accepts in_data this cycle.
REQ-011 SHALL have port kernel_rf_en, output, 1, active-low chip enable to all four banks.
REQ-012 SHALL have port kernel_rf_wr_en, output, 1, active-low write enable to all four banks.
REQ-013 SHALL have port kernel_rf_wr_addr, output, ADDR_W, shared write address.
REQ-014 SHALL have ports kernel1_rf_wr_data..kernel4_rf_wr_data, output signed, DATA_W each, per-bank write data.
REQ-015 SHALL have ports busy, output, 1, and done, output, 1 (one-cycle completion pulse).

Function
REQ-016 SHALL implement states IDLE, GATHER, WRITE, DONE.
REQ-017 IDLE: start accepted only here; on start with num_addr>0 go to GATHER, with num_addr=0 go to DONE; start while not IDLE SHALL be ignored.
REQ-018 GATHER: in_ready=1; each in_valid&&in_ready handshake stores in_data into lane register selected by lane counter 0..3 (lane 0 -> kernel1 ... lane 3 -> kernel4), then increments the lane counter.
REQ-019 Acceptance of lane 3 SHALL move to WRITE next cycle; in_ready=0 in WRITE, DONE and IDLE.
REQ-020 WRITE: exactly one cycle with kernel_rf_en=0, kernel_rf_wr_en=0, kernel_rf_wr_addr=current address, four lane registers on kernelN_rf_wr_data.
REQ-021 After WRITE: address increments modulo 2^ADDR_W (511 wraps to 0), remaining count decrements; remaining 0 -> DONE, else GATHER with lane counter 0.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE.
REQ-023 Outside WRITE: kernel_rf_en=1, kernel_rf_wr_en=1 (banks idle); wr_data holds last lane values.
REQ-024 busy=1 in GATHER, WRITE and DONE; 0 in IDLE.
REQ-025 Stalls (in_valid=0) in GATHER SHALL hold all state; no timeout.
REQ-026 Throughput: one address per 5 cycles with continuous in_valid; latency from 4th handshake to bank write = 1 cycle.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, lane counter 0, address 0, remaining 0, lane registers 0, in_ready=0, busy=0, done=0, kernel_rf_en=1, kernel_rf_wr_en=1, kernel_rf_wr_addr=0.
REQ-028 Reset mid-load SHALL abandon the load with no further bank write and no done pulse.

Configuration
REQ-029 Macro KERNEL_LOAD_CHECKSUM_EN defined: add output checksum (DATA_W+ADDR_W+2 bits, signed) = sum of all accepted weights since the last accepted start, cleared on start and reset, final value valid when done=1.
REQ-030 Macro undefined: no checksum port or accumulator; all other behaviour identical.

Structure
REQ-031 Shared package kernel_pkg SHALL hold DATA_W, ADDR_W, RF_DEPTH=512, NUM_KERNEL=4 and the state encoding.
REQ-032 Single flat module; no sub-module required.

Verification
REQ-033 Reset then start, base_addr=0, num_addr=1, stream 1,2,3,4 -> one WRITE cycle with addr 0, data 1/2/3/4 on kernel1..4, done pulse next cycle.
REQ-034 base_addr=510, num_addr=3, 12 weights -> writes at 510, 511, 0; done once.
REQ-035 num_addr=0 start -> no bank write, busy high one cycle, done one cycle after start.
REQ-036 in_valid toggled 1,0,1,0 during GATHER -> only handshaken words stored, in_ready low during WRITE, no lost or duplicated weight.
REQ-037 rst_n=0 after 2 of 4 weights -> kernel_rf_en/wr_en stay 1, no done, IDLE; new start loads correctly.
REQ-038 With KERNEL_LOAD_CHECKSUM_EN, weights -5,7,100,-2 -> checksum=100 at done; second start clears to 0.
